// File: rtl/circle_lines_scheduler_if.sv
// Bundle of signals around circle_lines_scheduler.
// The slave modport is the scheduler's view. It receives requests and generator
// results, and drives grants, generator controls, the forwarded tuples and job status.
// The master modport is the surrounding fabric and generator, i.e. the opposite view.
//   req_*      : per-requester valid/ready and packed argument slices
//   gen_*      : start/abort pulses, latched arguments, returned tuple, valid/done
//   _out*      : registered forwarded tuple with owner id
//   job_*      : completion pulse, owner id, tuple count, watchdog flag
interface circle_lines_scheduler_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0]            req_ready;
  logic [N_REQ-1:0][WIDTH-1:0] req_a, req_b, req_c, req_d;
  logic                        gen_start, gen_reset;
  logic signed [WIDTH-1:0]     gen_a, gen_b, gen_c, gen_d;
  logic signed [WIDTH-1:0]     gen_out0, gen_out1, gen_out2, gen_out3;
  logic                        gen_valid, gen_done;
  logic signed [WIDTH-1:0]     _out0, _out1, _out2, _out3;
  logic                        _out_valid;
  logic [ID_W-1:0]             _out_id;
  logic                        job_done;
  logic [ID_W-1:0]             job_id;
  logic [15:0]                 job_count;
  logic                        job_timeout;

  modport slave (
    input  req_valid, req_a, req_b, req_c, req_d,
    input  gen_out0, gen_out1, gen_out2, gen_out3, gen_valid, gen_done,
    output req_ready, gen_start, gen_reset, gen_a, gen_b, gen_c, gen_d,
    output _out0, _out1, _out2, _out3, _out_valid, _out_id,
    output job_done, job_id, job_count, job_timeout
  );

  modport master (
    output req_valid, req_a, req_b, req_c, req_d,
    output gen_out0, gen_out1, gen_out2, gen_out3, gen_valid, gen_done,
    input  req_ready, gen_start, gen_reset, gen_a, gen_b, gen_c, gen_d,
    input  _out0, _out1, _out2, _out3, _out_valid, _out_id,
    input  job_done, job_id, job_count, job_timeout
  );
endinterface

// File: rtl/circle_lines_scheduler.sv
// Round-robin job scheduler sharing one circle_lines generator among N_REQ requesters.
// It grants one argument set at a time and pulses gen_start.
// While the job runs, it forwards every generator tuple tagged with the owner id.
// It ends the job on gen_done, or aborts it with gen_reset when the watchdog expires.
// Ports:
//   _clock : rising-edge clock
//   _reset : asynchronous active-high reset
//   bus    : circle_lines_scheduler_if slave (requests, generator, forwarded tuples, job status)
module circle_lines_scheduler #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 32,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 1023
) (
  input logic                     _clock,
  input logic                     _reset,
  circle_lines_scheduler_if.slave bus
);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_RUN, S_DONE, S_ABORT} state_t;

  state_t                 state, state_nxt;
  logic [ID_W-1:0]        rr_ptr, cur_id, grant;
  logic                   grant_vld, accept, wd_last;
  logic [15:0]            count;
  logic [WD_W-1:0]        wdog;
  logic [3:0][WIDTH-1:0]  arg_q, out_q;
  logic                   out_vld;
  logic [ID_W-1:0]        out_id;

  // First pending requester at or after rr_ptr, wrapping modulo N_REQ.
  // The loop walks offsets high to low, so the smallest offset is assigned last and wins.
  always_comb begin
    int idx;
    grant     = '0;
    grant_vld = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = int'(rr_ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (bus.req_valid[idx]) begin
        grant     = ID_W'(idx);
        grant_vld = 1'b1;
      end
    end
  end

  // req_ready is only ever raised for the grant in IDLE, so any grant in IDLE is an accept.
  assign accept  = (state == S_IDLE) && grant_vld;
  // wdog holds the number of RUN cycles already completed.
  // When wdog == TIMEOUT-1, the current cycle is RUN cycle TIMEOUT.
  assign wd_last = (wdog == WD_W'(TIMEOUT - 1));

  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    bus.req_ready   = '0;
    bus.gen_start   = 1'b0;
    bus.gen_reset   = 1'b0;
    bus.job_done    = 1'b0;
    bus.job_timeout = 1'b0;
    case (state)
      S_IDLE: begin
        if (grant_vld && !_reset) bus.req_ready[grant] = 1'b1;
        if (grant_vld) state_nxt = S_START;
      end
      S_START: begin
        bus.gen_start = 1'b1;
        state_nxt     = S_RUN;
      end
      S_RUN: begin
        // gen_done wins over a watchdog expiry in the same cycle.
        if (bus.gen_done)  state_nxt = S_DONE;
        else if (wd_last)  state_nxt = S_ABORT;
      end
      S_DONE: begin
        bus.job_done = 1'b1;
        state_nxt    = S_IDLE;
      end
      S_ABORT: begin
        bus.gen_reset   = 1'b1;
        bus.job_done    = 1'b1;
        bus.job_timeout = 1'b1;
        state_nxt       = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset) begin
      rr_ptr  <= '0;
      cur_id  <= '0;
      count   <= '0;
      wdog    <= '0;
      arg_q   <= '0;
      out_q   <= '0;
      out_vld <= 1'b0;
      out_id  <= '0;
    end else begin
      out_vld <= 1'b0;
      if (accept) begin
        arg_q  <= {bus.req_d[grant], bus.req_c[grant], bus.req_b[grant], bus.req_a[grant]};
        cur_id <= grant;
        rr_ptr <= (int'(grant) == N_REQ - 1) ? '0 : grant + 1'b1;
        count  <= '0;
        wdog   <= '0;
      end
      if (state == S_RUN) begin
        wdog <= wdog + 1'b1;
        if (bus.gen_valid) begin
          out_q   <= {bus.gen_out3, bus.gen_out2, bus.gen_out1, bus.gen_out0};
          out_vld <= 1'b1;
          out_id  <= cur_id;
          if (count != 16'hFFFF) count <= count + 16'd1;
        end
      end
    end
  end

  assign bus.gen_a      = arg_q[0];
  assign bus.gen_b      = arg_q[1];
  assign bus.gen_c      = arg_q[2];
  assign bus.gen_d      = arg_q[3];
  assign bus._out0      = out_q[0];
  assign bus._out1      = out_q[1];
  assign bus._out2      = out_q[2];
  assign bus._out3      = out_q[3];
  assign bus._out_valid = out_vld;
  assign bus._out_id    = out_id;
  // Status fields read as zero outside the completion pulse.
  assign bus.job_id     = bus.job_done ? cur_id : '0;
  assign bus.job_count  = bus.job_done ? count  : '0;
endmodule

// File: tb/tb_circle_lines_scheduler.sv
// Randomized bench for circle_lines_scheduler.
// Requesters and a generator model are driven from a per-cycle loop.
// Expected behaviour comes from an event-time reference: grant choice, start cycle,
// a queue of tuples due one cycle after they are produced, and the predicted job end.
module tb_circle_lines_scheduler;
  localparam int N = 4, W = 32, IDW = 2, TO = 20;
  localparam int M_SHORT = 0, M_SINGLE = 1, M_SIM = 2, M_HANG = 3, M_EDGE = 4, M_RAND = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  circle_lines_scheduler_if #(.N_REQ(N), .WIDTH(W), .ID_W(IDW)) bus ();
  circle_lines_scheduler #(.N_REQ(N), .WIDTH(W), .ID_W(IDW), .TIMEOUT(TO)) dut (
    ._clock(clk), ._reset(rst), .bus(bus)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct { int due; logic [127:0] data; logic [IDW-1:0] id; } tup_t;
  tup_t tq[$];
  int   grants[$];

  logic [N-1:0]   want, refill;
  logic [W-1:0]   ra[N], rb[N], rc[N], rd[N];
  logic [4*W-1:0] args_l;
  bit   job_act, to_flag;
  int   cyc, exp_ptr, cur, start_cyc, done_cyc, cnt, jobs, mode;
  int   plan_done, vprob, vd, arrive_pct, drop_ok, obs_cnt, obs_to;

  task automatic new_args(int i);
    ra[i] = $urandom; rb[i] = $urandom; rc[i] = $urandom; rd[i] = $urandom;
  endtask

  // Generator behaviour for the job just accepted.
  // plan_done is the RUN cycle that raises gen_done; 0 means it never does.
  task automatic plan(int m);
    if (m == M_RAND) begin
      case ($urandom_range(5))
        0: m = M_HANG;
        1: m = M_EDGE;
        2: m = M_SIM;
        default: m = M_RAND;
      endcase
    end
    case (m)
      M_SHORT:  begin plan_done = 1 + $urandom_range(3); vprob = 50;  vd = 2; end
      M_SINGLE: begin plan_done = 9;                      vprob = 100; vd = 0; end
      M_SIM:    begin plan_done = 3 + $urandom_range(7); vprob = 50;  vd = 1; end
      M_HANG:   begin plan_done = 0;                      vprob = 30;  vd = 0; end
      M_EDGE:   begin plan_done = TO;                     vprob = 40;  vd = 2; end
      default:  begin plan_done = 1 + $urandom_range(11); vprob = $urandom_range(100); vd = 2; end
    endcase
  endtask

  task automatic step();
    logic [N-1:0]   rdy;
    logic [127:0]   gdat;
    logic           gv, gd;
    bit             in_run;
    int             g, ri;
    tup_t           t;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i] = ra[i]; bus.req_b[i] = rb[i]; bus.req_c[i] = rc[i]; bus.req_d[i] = rd[i];
    end
    bus.req_valid = want;
    gdat   = {$urandom, $urandom, $urandom, $urandom};
    gv     = 1'b0;
    gd     = 1'b0;
    ri     = 0;
    in_run = job_act && cyc > start_cyc && done_cyc < 0;
    if (in_run) begin
      ri = cyc - start_cyc;
      if (ri == plan_done) begin
        gd = 1'b1;
        gv = (vd == 2) ? ($urandom_range(99) < vprob) : (vd == 1);
      end else gv = ($urandom_range(99) < vprob);
    end else gv = ($urandom_range(7) == 0);
    bus.gen_valid = gv;
    bus.gen_done  = gd;
    {bus.gen_out3, bus.gen_out2, bus.gen_out1, bus.gen_out0} = gdat;
    #1;
    rdy = '0;
    g   = -1;
    if (!job_act) begin
      for (int k = 0; k < N; k++)
        if (want[(exp_ptr + k) % N]) begin g = (exp_ptr + k) % N; break; end
      if (g >= 0) rdy[g] = 1'b1;
    end
    chk("req_ready", bus.req_ready, rdy);
    chk("gen_start", bus.gen_start, job_act && cyc == start_cyc);
    chk("job_done", bus.job_done, job_act && cyc == done_cyc);
    chk("gen_reset", bus.gen_reset, job_act && cyc == done_cyc && to_flag);
    if (job_act && cyc == done_cyc) begin
      chk("job_id", bus.job_id, cur);
      chk("job_count", bus.job_count, cnt);
      chk("job_timeout", bus.job_timeout, to_flag);
      obs_cnt = bus.job_count;
      obs_to  = bus.job_timeout;
    end
    if (job_act && cyc >= start_cyc)
      chk("gen_args", {bus.gen_d, bus.gen_c, bus.gen_b, bus.gen_a}, args_l);
    if (tq.size() > 0 && tq[0].due == cyc) begin
      t = tq.pop_front();
      chk("out_valid", bus._out_valid, 1);
      chk("out_data", {bus._out3, bus._out2, bus._out1, bus._out0}, t.data);
      chk("out_id", bus._out_id, t.id);
    end else chk("out_valid", bus._out_valid, 0);
    // the edge that ends this cycle
    if (g >= 0) begin
      grants.push_back(g);
      job_act = 1; cur = g; start_cyc = cyc + 1; done_cyc = -1; to_flag = 0; cnt = 0;
      exp_ptr = (g + 1) % N;
      args_l  = {rd[g], rc[g], rb[g], ra[g]};
      want[g] = refill[g];
      if (refill[g]) new_args(g);
      plan(mode);
    end
    if (in_run) begin
      if (gv) begin
        tq.push_back('{cyc + 1, gdat, IDW'(cur)});
        if (cnt < 65535) cnt++;
      end
      if (gd) begin done_cyc = cyc + 1; to_flag = 0; end
      else if (ri == TO) begin done_cyc = cyc + 1; to_flag = 1; end
    end else if (job_act && cyc == done_cyc) begin
      job_act = 0;
      jobs++;
    end
    for (int i = 0; i < N; i++) begin
      if (!want[i] && arrive_pct > 0 && $urandom_range(99) < arrive_pct) begin
        want[i] = 1'b1; new_args(i);
      end else if (want[i] && drop_ok != 0 && g != i && $urandom_range(39) == 0) want[i] = 1'b0;
    end
    cyc++;
  endtask

  task automatic run_jobs(int target, int budget);
    for (int t = 0; t < budget && jobs < target; t++) step();
    chk("job_budget", jobs, target);
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_ready"}, bus.req_ready, 0);
    chk({tag, "_start"}, bus.gen_start, 0);
    chk({tag, "_greset"}, bus.gen_reset, 0);
    chk({tag, "_done"}, {bus.job_done, bus.job_timeout, bus.job_id, bus.job_count}, 0);
    chk({tag, "_ovalid"}, {bus._out_valid, bus._out_id}, 0);
    chk({tag, "_odata"}, {bus._out3, bus._out2, bus._out1, bus._out0}, 0);
    chk({tag, "_args"}, {bus.gen_d, bus.gen_c, bus.gen_b, bus.gen_a}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_guard: got time %0t expected end of run", $time);
    $fatal(1, "bench did not finish");
  end

  initial begin
    int rr_exp[5] = '{0, 1, 2, 3, 0};
    want = '0; refill = '0; arrive_pct = 0; drop_ok = 0; mode = M_SHORT;
    job_act = 0; to_flag = 0; exp_ptr = 0; cyc = 0; jobs = 0; cur = 0;
    start_cyc = -1; done_cyc = -1; cnt = 0; obs_cnt = 0; obs_to = 0;
    for (int i = 0; i < N; i++) new_args(i);
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.req_c = '0; bus.req_d = '0;
    bus.gen_valid = 1'b0; bus.gen_done = 1'b0;
    bus.gen_out0 = '0; bus.gen_out1 = '0; bus.gen_out2 = '0; bus.gen_out3 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    // round robin with all four held valid from reset
    want = '1; refill = '1; mode = M_SHORT;
    run_jobs(5, 400);
    for (int k = 0; k < 5; k++) chk("rr_order", grants[k], rr_exp[k]);

    // pointer skip: grant 1 leaves the pointer at 2, then only 0 and 1 ask
    refill = '0; want = 4'b0010; new_args(1);
    run_jobs(6, 200);
    want = 4'b0011; new_args(0); new_args(1);
    run_jobs(8, 300);
    chk("skip_g1", grants[5], 1);
    chk("skip_g0", grants[6], 0);
    chk("skip_g1b", grants[7], 1);

    // single job from requester 0 with fixed arguments and 8 tuples
    want = 4'b0001; ra[0] = 23; rb[0] = 17; rc[0] = 5; rd[0] = 0; mode = M_SINGLE;
    run_jobs(9, 200);
    chk("single_count", obs_cnt, 8);
    chk("single_to", obs_to, 0);

    // gen_valid and gen_done together
    want = 4'b1000; new_args(3); mode = M_SIM;
    run_jobs(10, 200);

    // gen_done exactly on RUN cycle TIMEOUT completes normally
    want = 4'b0010; new_args(1); mode = M_EDGE;
    run_jobs(11, 200);
    chk("edge_to", obs_to, 0);

    // watchdog abort, then a fresh request is still served
    want = 4'b0100; new_args(2); mode = M_HANG;
    run_jobs(12, 200);
    chk("timeout_flag", obs_to, 1);
    want = 4'b0010; new_args(1); mode = M_SHORT;
    run_jobs(13, 200);
    chk("after_to_grant", grants[grants.size() - 1], 1);

    // random traffic with arrivals, early drops and mixed generator behaviour
    mode = M_RAND; arrive_pct = 20; drop_ok = 1;
    run_jobs(43, 4000);
    arrive_pct = 0; drop_ok = 0; want = '0;

    // reset while the third tuple is on the generator port
    want = 4'b0100; new_args(2); mode = M_SINGLE;
    for (int t = 0; t < 100 && !(job_act && cnt == 2 && done_cyc < 0); t++) step();
    chk("reset_reach", cnt, 2);
    @(posedge clk); #1;
    bus.gen_valid = 1'b1; bus.gen_done = 1'b0;
    #1 rst = 1'b1;
    #1 chk_all_zero("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    job_act = 0; exp_ptr = 0; done_cyc = -1; tq.delete();
    want = 4'b1100; new_args(2); new_args(3); mode = M_SHORT;
    run_jobs(jobs + 1, 200);
    chk("post_reset_grant", grants[grants.size() - 1], 2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/circle_lines_scheduler.md
# circle_lines_scheduler

Round-robin job scheduler that shares one `circle_lines` generator instance among `N_REQ` requesters. It arbitrates argument sets `(a, b, c, d)`, launches the generator with a one-cycle `_start`, and forwards each output tuple tagged with the owning requester ID. It reports per-job completion, with an output count and a watchdog timeout. It sits between the request fabric and the generator datapath; the generator's ports connect 1:1 to the `gen_*` ports.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `WIDTH`, 32: signed data width of arguments and outputs.
- `ID_W`, 2: requester ID width, `clog2(N_REQ)`.
- `TIMEOUT`, 1023: maximum cycles in RUN before abort.
- `_clock`  in  1  single clock, all state on rising edge.
- `_reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  N_REQ  request pending, one bit per requester.
- `req_a`, `req_b`, `req_c`, `req_d`  in  N_REQ*WIDTH each  packed signed arguments; requester i uses slice i.
- `req_ready`  out  N_REQ  one-hot accept, combinational.
- `gen_start`  out  1  one-cycle launch pulse to the generator.
- `gen_reset`  out  1  one-cycle abort pulse to the generator.
- `gen_a`, `gen_b`, `gen_c`, `gen_d`  out  WIDTH  latched arguments, stable from START to job end.
- `gen_out0`..`gen_out3`  in  WIDTH  generator output tuple.
- `gen_valid`  in  1  generator tuple valid.
- `gen_done`  in  1  generator finished.
- `_out0`..`_out3`  out  WIDTH  forwarded tuple, registered.
- `_out_valid`  out  1  forwarded tuple valid.
- `_out_id`  out  ID_W  owner of the forwarded tuple.
- `job_done`  out  1  one-cycle completion pulse.
- `job_id`  out  ID_W  requester of the completed job.
- `job_count`  out  16  tuples forwarded for that job, saturating.
- `job_timeout`  out  1  job ended by watchdog; qualified by `job_done`.

## Operation
- FSM states: IDLE, START, RUN, DONE, ABORT.
- **IDLE:**
  - If any `req_valid` is high, grant the first set bit at or after `rr_ptr` (wrap modulo `N_REQ`).
  - `req_ready[g]=1` only in IDLE and only for the grant.
  - Handshake is `req_valid & req_ready` at the edge; a requester holds `req_valid` and its arguments until accepted.
  - On accept: latch arguments into `gen_a`..`gen_d`, latch `cur_id=g`, set `rr_ptr=(g+1) mod N_REQ`, clear the count and watchdog, go to START.
- **START:** `gen_start=1` for exactly this cycle; go to RUN.
- **RUN:**
  - Each cycle with `gen_valid=1`: register the tuple to `_out*`, with `_out_valid=1` and `_out_id=cur_id`, and increment the count (saturating at 0xFFFF).
  - `gen_done=1`: go to DONE. A `gen_valid` in the same cycle is still forwarded and counted.
  - Watchdog reaching `TIMEOUT` with no `gen_done`: go to ABORT.
  - `gen_valid` outside RUN is ignored; `_out_valid` stays 0.
- **DONE:** `job_done=1`, `job_id=cur_id`, `job_count` = final count, `job_timeout=0`; go to IDLE.
- **ABORT:** `gen_reset=1`, `job_done=1`, `job_timeout=1`, `job_count` = count so far; go to IDLE.
- Only one job is in flight at a time; no requests are accepted outside IDLE.

## Timing
- Reset value of all outputs and state is 0: state IDLE, `rr_ptr=0`, no pulses. Argument and `_out*` registers also reset to 0.
- Reset mid-job: immediate return to IDLE. No `job_done` is issued, and the job is lost; its requester must re-request.
- Accept edge T:
  - `gen_start` is high during cycle T+1.
  - RUN begins at T+2.
- `gen_valid` in cycle k appears on `_out_valid` in cycle k+1 (one-cycle latency).
- `gen_done` sampled at edge E: `job_done` is high during the cycle after E. The earliest next accept is the edge ending that cycle's successor IDLE cycle, i.e. 3 cycles of turnaround between jobs.
- Watchdog:
  - Counts RUN cycles starting at 1.
  - Abort is taken when the count equals `TIMEOUT` and `gen_done` is low.
  - `gen_done` in that same cycle wins, and the job completes normally.
- `req_valid` dropped before accept: no grant and no state change.

## Test plan
- **Single job.** Requester 0 issues `a=23, b=17, c=5, d=0`; the generator model emits 8 tuples, then `gen_done`.
  - Expect one `gen_start` pulse, 8 `_out_valid` beats with `_out_id=0` and tuples matching the model one cycle later.
  - Expect `job_done` with `job_count=8`, `job_timeout=0`.
- **Round robin.** All four requesters held valid from reset.
  - Grant order is 0,1,2,3,0; each `req_ready` is one-hot, one cycle long.
  - `job_id` sequence matches the grant order.
- **Pointer skip.** `rr_ptr=2`, only requesters 0 and 1 valid → grant 0, then 1.
- **Simultaneous valid and done.** `gen_valid` and `gen_done` are high in the same cycle → that tuple is forwarded and `job_count` includes it.
- **Timeout.** `TIMEOUT=20`, the model never asserts `gen_done`.
  - Expect a `gen_reset` pulse in the cycle after RUN cycle 20.
  - Expect `job_done=1`, `job_timeout=1`, and the next request accepted afterwards.
- **Reset mid-RUN.** Assert `_reset` during tuple 3 → all outputs 0 immediately and no `job_done`. After release, a new request from requester 2 is granted with `rr_ptr=0` semantics.
